// File: rtl/cpu_ifetch_q.sv
// -----------------------------------------------------------------------------
// cpu_ifetch_q -- instruction fetch unit with a small decoupling queue.
//
// A fetch PC (i_pc) walks a read-only instruction memory one word per cycle.
// Each read is registered: issued at edge N, it lands in the fetch queue at
// edge N+1 tagged with its issue PC. The consumer drains the queue head with
// a valid/ready handshake. A redirect flushes the queue and any in-flight
// read and restarts fetch at a new PC. Reset has priority over everything.
//
// Parameters:
//   RESET_VECTOR          first fetch PC after reset
//   INSTR_MEM_ADDR_WIDTH  log2 of instruction memory depth (32-bit words)
//   FQ_DEPTH              fetch queue entries (power of two, 2..64)
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch PC
//   f_valid         queue head holds a valid instruction
//   f_ready         consumer accepts the head this cycle
//   f_instr         head instruction (NOP 32'h13 when empty)
//   f_pc            head PC (0 when empty)
//   f_misalign      head came from a misaligned redirect (optional)
//
// Optional feature: define IFETCH_MISALIGN_CHK_EN to keep redirect_pc[1:0],
// tag the first fetch after a misaligned redirect with f_misalign, and stall
// issue after it until the next redirect or reset. Without the macro the
// port is absent and redirect_pc[1:0] is treated as zero.
//
// instr_mem has no write port; its contents are loaded from outside.
// -----------------------------------------------------------------------------
module cpu_ifetch_q #(
  parameter logic [31:0] RESET_VECTOR         = 32'h0000_0000,
  parameter int          INSTR_MEM_ADDR_WIDTH = 10,
  parameter int          FQ_DEPTH             = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        f_valid,
  input  logic        f_ready,
  output logic [31:0] f_instr,
  output logic [31:0] f_pc
`ifdef IFETCH_MISALIGN_CHK_EN
  ,
  output logic        f_misalign
`endif
);

  localparam int          MEM_DEPTH = 1 << INSTR_MEM_ADDR_WIDTH;
  localparam int          PTR_W     = $clog2(FQ_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  // Wide enough to hold count + inflight without overflow.
  localparam int          OCC_W     = PTR_W + 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  // Read-only instruction store.
  logic [31:0] instr_mem [MEM_DEPTH];

  // Control state.
  logic [31:0]      i_pc_q, i_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             inflight_q, inflight_d;

  // Registered memory read and its tag.
  logic [31:0] rd_data_q;
  logic [31:0] rd_pc_q;

  // Queue storage.
  logic [31:0] q_instr [FQ_DEPTH];
  logic [31:0] q_pc    [FQ_DEPTH];

`ifdef IFETCH_MISALIGN_CHK_EN
  logic stall_q, stall_d;
  logic rd_mis_q;
  logic q_mis [FQ_DEPTH];
  logic misaligned;
`endif

  logic             empty;
  logic             pop;
  logic             q_wr;
  logic             issue;
  logic             stalled;
  logic [OCC_W-1:0] occupancy;

  // ---------------------------------------------------------------------------
  // Handshake and issue decision
  // ---------------------------------------------------------------------------
  assign empty   = (count_q == '0);
  assign f_valid = !empty;
  assign pop     = f_valid & f_ready;
  // Whatever was read last cycle lands in the queue this edge.
  assign q_wr    = inflight_q;

  // Slots that will be occupied after this edge if nothing new is issued;
  // issuing only when this is below FQ_DEPTH keeps count <= FQ_DEPTH.
  assign occupancy = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);

`ifdef IFETCH_MISALIGN_CHK_EN
  assign misaligned = (i_pc_q[1:0] != 2'b00);
  assign stalled    = stall_q;
`else
  assign stalled    = 1'b0;
`endif

  assign issue = !redirect_valid && !stalled && (occupancy < OCC_W'(FQ_DEPTH));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    i_pc_d     = i_pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    inflight_d = inflight_q;
`ifdef IFETCH_MISALIGN_CHK_EN
    stall_d    = stall_q;
`endif

    if (redirect_valid) begin
      // Flush wins over a simultaneous pop and over the in-flight write.
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
      inflight_d = 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
      i_pc_d     = redirect_pc;
      stall_d    = 1'b0;
`else
      i_pc_d     = redirect_pc & ~32'h0000_0003;
`endif
    end else begin
      inflight_d = issue;
      if (issue) begin
        i_pc_d = i_pc_q + 32'd4;
      end
`ifdef IFETCH_MISALIGN_CHK_EN
      // The misaligned fetch itself goes out; nothing after it does.
      if (issue && misaligned) begin
        stall_d = 1'b1;
      end
`endif
      if (q_wr) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CNT_W'(q_wr) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      i_pc_q     <= RESET_VECTOR;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
`ifdef IFETCH_MISALIGN_CHK_EN
      stall_q    <= 1'b0;
`endif
    end else begin
      i_pc_q     <= i_pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= inflight_d;
`ifdef IFETCH_MISALIGN_CHK_EN
      stall_q    <= stall_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath: synchronous memory read and queue storage
  // ---------------------------------------------------------------------------
  // NOTE: read data and queue entries carry no reset; validity is tracked by
  // inflight_q and count_q alone, so these map onto plain RAM/flop arrays.
  always_ff @(posedge clk) begin
    if (issue) begin
      // Upper PC bits are dropped here, so addresses alias modulo the memory.
      rd_data_q <= instr_mem[i_pc_q[INSTR_MEM_ADDR_WIDTH+1:2]];
      rd_pc_q   <= i_pc_q;
`ifdef IFETCH_MISALIGN_CHK_EN
      rd_mis_q  <= misaligned;
`endif
    end
    if (q_wr) begin
      q_instr[tail_q] <= rd_data_q;
      q_pc[tail_q]    <= rd_pc_q;
`ifdef IFETCH_MISALIGN_CHK_EN
      q_mis[tail_q]   <= rd_mis_q;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    f_instr = NOP;
    f_pc    = '0;
    if (!empty) begin
      f_instr = q_instr[head_q];
      f_pc    = q_pc[head_q];
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  assign f_misalign = !empty && q_mis[head_q];
`endif

endmodule
